// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: zero or more pointer fetches followed by a
// final load or store, with byte-lane steering, alignment faults and a result
// hold buffer so a finished access is never re-issued while the pipeline stalls.
//
// state  | meaning
// ACCESS | issuing pointer fetches / final access for the current op
// HOLD   | final access done, pipeline stalled, result held in hdata
module mem_stage_ctrl #(
   parameter int DATA_W  = 16,
   parameter int MAX_IND = 2,
   parameter int BE_W    = DATA_W / 8,
   parameter int IND_W   = (MAX_IND > 0) ? $clog2(MAX_IND + 1) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        op,
   input  logic [IND_W-1:0]  ind_levels,
   input  logic [DATA_W-1:0] base_addr,
   input  logic [DATA_W-1:0] vec_addr,
   input  logic [DATA_W-1:0] src_data,
   input  logic              advance,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              data_response,
   output logic              data_request,
   output logic              write_enable,
   output logic [DATA_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [BE_W-1:0]   mem_byte_enable,
   output logic [DATA_W-1:0] mem_output,
   output logic              ready,
   output logic              align_fault
);

   localparam int LW = $clog2(BE_W);
   localparam logic [IND_W-1:0] MAX_L = IND_W'(MAX_IND);

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_LDW  = 3'd1;
   localparam logic [2:0] OP_LDB  = 3'd2;
   localparam logic [2:0] OP_STW  = 3'd3;
   localparam logic [2:0] OP_STB  = 3'd4;
   localparam logic [2:0] OP_VEC  = 3'd5;

   typedef enum logic {ACCESS = 1'b0, HOLD = 1'b1} state_t;

   state_t            state;
   logic [IND_W-1:0]  lvl;
   logic [DATA_W-1:0] ptr;
   logic [DATA_W-1:0] hdata;

   logic [IND_W-1:0]  lvl_target;
   logic              op_valid;
   logic              fetch;
   logic              is_word;
   logic              misaligned;
   logic              fault;
   logic [DATA_W-1:0] cur_addr;
   logic [LW-1:0]     lane;
   logic [7:0]        rd_byte;

   // Decode the current transaction: target level, address, lane and fault.
   always_comb begin
      lvl_target = (ind_levels > MAX_L) ? MAX_L : ind_levels;
      op_valid   = (op == OP_LDW) || (op == OP_LDB) || (op == OP_STW) ||
                   (op == OP_STB) || (op == OP_VEC);
      fetch      = (lvl < lvl_target);
      if (op == OP_VEC)
         cur_addr = vec_addr;
      else if (lvl == '0)
         cur_addr = base_addr;
      else
         cur_addr = ptr;
      lane       = cur_addr[LW-1:0];
      is_word    = fetch || (op == OP_LDW) || (op == OP_STW) || (op == OP_VEC);
      misaligned = |cur_addr[LW-1:0];
      fault      = (state == ACCESS) && op_valid && is_word && misaligned;
      rd_byte    = 8'(mem_rdata >> {lane, 3'b000});
   end

   // Port outputs; reset forces the idle defaults so an abandoned request drops at once.
   always_comb begin
      data_request    = 1'b0;
      write_enable    = 1'b0;
      mem_address     = '0;
      mem_wdata       = '0;
      mem_byte_enable = '1;
      mem_output      = '0;
      ready           = 1'b1;
      align_fault     = 1'b0;
      if (rst_n) begin
         if (state == HOLD) begin
            mem_output = hdata;
         end else if (fault) begin
            align_fault = 1'b1;
         end else if (op_valid) begin
            data_request = 1'b1;
            mem_address  = cur_addr;
            if (fetch) begin
               ready = 1'b0;
            end else begin
               ready = data_response;
               case (op)
                  OP_LDW, OP_VEC: mem_output = mem_rdata;
                  OP_LDB:         mem_output = DATA_W'(rd_byte);
                  OP_STW: begin
                     write_enable = 1'b1;
                     mem_wdata    = src_data;
                  end
                  OP_STB: begin
                     write_enable    = 1'b1;
                     mem_wdata       = DATA_W'(src_data[7:0]) << {lane, 3'b000};
                     mem_byte_enable = BE_W'(1) << lane;
                  end
                  default: mem_output = '0;
               endcase
            end
         end
      end
   end

   // Sequencer: advance through pointer levels, then complete or park in HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCESS;
         lvl   <= '0;
         ptr   <= '0;
         hdata <= '0;
      end else begin
         case (state)
            ACCESS: begin
               if (fault || !op_valid) begin
                  if (advance) lvl <= '0;
               end else if (data_response) begin
                  if (fetch) begin
                     ptr <= mem_rdata;
                     lvl <= lvl + IND_W'(1);
                  end else if (advance) begin
                     lvl <= '0;
                  end else begin
                     hdata <= mem_output;
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (advance) begin
                  lvl   <= '0;
                  state <= ACCESS;
               end
            end
            default: state <= ACCESS;
         endcase
      end
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Parametrised memory-stage access controller for the pipelined LC-3b datapath, successor to the fixed two-hit load/store sequencer. It turns a decoded memory operation into one or more data-port transactions: zero to MAX_IND pointer fetches, then a final load or store. It adds configurable data width, byte-lane steering, alignment faults and a result hold buffer, so a finished access is never re-issued while the pipeline is stalled. It sits between the EX/MEM pipeline register and the data cache port.

## Interface
- DATA_W, 16: data and address width; multiple of 8, at least 16.
- MAX_IND, 2: maximum pointer-fetch levels per operation.
- BE_W, DATA_W/8: byte-enable width (derived).
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  3  0 none, 1 load word, 2 load byte, 3 store word, 4 store byte, 5 vector load (word, address from vec_addr).
- ind_levels  in  $clog2(MAX_IND+1)  pointer fetches before the final access; values above MAX_IND are clamped to MAX_IND.
- base_addr  in  DATA_W  effective address from the ALU.
- vec_addr  in  DATA_W  zero-extended trap vector address.
- src_data  in  DATA_W  store data.
- advance  in  1  pipeline moves this cycle.
- mem_rdata  in  DATA_W  read data.
- data_response  in  1  the current transaction completes this cycle.
- data_request  out  1  transaction valid.
- write_enable  out  1  write transaction.
- mem_address  out  DATA_W  transaction address.
- mem_wdata  out  DATA_W  write data.
- mem_byte_enable  out  BE_W  active byte lanes.
- mem_output  out  DATA_W  load result.
- ready  out  1  stage may advance.
- align_fault  out  1  a word access hit an address not aligned to DATA_W/8.

## Operation
- States: ACCESS and HOLD. Registers: level counter lvl, pointer register ptr, hold register hdata.
- Current address: vec_addr if op=5; otherwise base_addr when lvl=0, else ptr.
- ACCESS with op=0: no request, ready=1, all outputs at default.
- ACCESS with lvl < ind_levels (pointer fetch):
  - word read, data_request=1, ready=0;
  - on data_response: ptr<=mem_rdata and lvl<=lvl+1.
- ACCESS with lvl = ind_levels (final access):
  - data_request=1 and ready=data_response;
  - load word or vector load: mem_output=mem_rdata;
  - load byte: mem_output = selected lane zero-extended, lane = address[$clog2(BE_W)-1:0];
  - store word: write_enable=1, mem_wdata=src_data, mem_byte_enable all ones;
  - store byte: src_data[7:0] placed in the selected lane, other lanes 0, one-hot byte enable.
- At final completion (data_response=1):
  - with advance=1: lvl<=0 and stay in ACCESS;
  - with advance=0: hdata<=mem_output value, go to HOLD.
- HOLD: data_request=0, ready=1, mem_output=hdata. On advance: lvl<=0 and go to ACCESS.
- Alignment fault:
  - applies to any word access (pointer, word load/store, vector) whose address has nonzero low $clog2(BE_W) bits;
  - response: align_fault=1, data_request=0, ready=1, mem_output=0;
  - advance clears lvl; no state change.
- Defaults: mem_byte_enable all ones; other outputs 0; ready=1.
- op, ind_levels, base_addr and src_data must be stable while ready=0.

## Timing
- Reset (rst_n=0, asynchronous): state ACCESS, lvl=0, ptr=0, hdata=0.
  - While rst_n is low all outputs are forced to defaults: data_request=0, ready=1, align_fault=0.
  - Reset mid-transaction abandons it; the port drops the request in the same cycle.
- All outputs are combinational from state, registers and inputs; no registered output delay.
- Minimum latency (zero-wait memory): ind_levels+1 cycles, one per transaction. Each transaction holds its request until data_response.
- A pointer fetch and the following access are never issued in the same cycle.
- data_response while data_request=0 is ignored.
- A data_response that completes the final access on the same edge as advance does not enter HOLD; the next op starts in the following cycle.

## Test plan
- Load word, ind_levels=0, base 0x3000, rdata 0xBEEF with a 2-cycle wait -> request held 3 cycles, ready in cycle 3, mem_output=0xBEEF.
- Indirect store, ind_levels=2, pointer reads return 0x4000 then 0x5000 -> third transaction writes src_data to 0x5000 with byte enable 2'b11; ready only on the third response.
- Byte load at 0x3001, rdata 0xA55A -> mem_output=0x00A5. Byte store at 0x3001 of 0x12 -> wdata 0x1200, enable 2'b10.
- Final response with advance=0 for 3 cycles -> exactly one request, then ready=1 with mem_output held at the loaded value; ACCESS resumes after advance.
- Word load at 0x3003 -> align_fault=1, no request, ready=1. DATA_W=32 byte load at 0x...2 -> lane 2 selected.
- Assert rst_n low mid pointer fetch -> request drops immediately; after release a fresh op starts at lvl 0.
